// File: rtl/mcs51_xbus_pkg.sv
// Shared types and constants for the MCS-51 external-bus cycle sequencer.
package mcs51_xbus_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_STRB  = 3'd3,
        ST_RECOV = 3'd4
    } xb_state_e;

    typedef enum logic [1:0] {
        XB_FETCH = 2'b00,
        XB_READ  = 2'b01,
        XB_WRITE = 2'b10
    } xb_kind_e;

    // The reserved encoding 2'b11 runs as an ordinary data read.
    function automatic xb_kind_e kind_decode(input logic [1:0] kind);
        xb_kind_e k;
        case (kind)
            2'b00:   k = XB_FETCH;
            2'b10:   k = XB_WRITE;
            default: k = XB_READ;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mcs51_xbus_seq_phase_cnt.sv
// Loadable down-counter with zero flag that times every phase of the bus cycle.
module xbus_phase_cnt
    import mcs51_xbus_pkg::*;
(
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load has priority; the count saturates at zero so wait states can park on it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mcs51_xbus_seq.sv
// 8051-style multiplexed external bus cycle sequencer (P0/P2, ALE, PSEN_n, RD_n, WR_n).
// Optional READY wait-state input is enabled by defining MCS51_XBUS_WAIT_EN.
module mcs51_xbus_seq
    import mcs51_xbus_pkg::*;
#(
    parameter int ALE_CYC  = 2,
    parameter int HOLD_CYC = 1,
    parameter int STRB_CYC = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        REQ,
    input  logic [1:0]  KIND,
    input  logic [15:0] ADDR,
    input  logic [7:0]  WDATA,
`ifdef MCS51_XBUS_WAIT_EN
    input  logic        READY,
`endif
    output logic        BUSY,
    output logic        ACK,
    output logic [7:0]  RDATA,
    output logic        ALE,
    output logic        PSEN_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic [7:0]  P0_OUT,
    output logic        P0_OE,
    input  logic [7:0]  P0_IN,
    output logic [7:0]  P2_OUT
);

    localparam logic [CNT_W-1:0] ALE_LD  = CNT_W'(ALE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STRB_LD = CNT_W'(STRB_CYC - 1);

    xb_state_e  state_r;
    xb_kind_e   kind_r;
    logic [7:0] wdata_r;
    logic       busy_r;
    logic       ack_r;
    logic [7:0] rdata_r;
    logic       ale_r;
    logic       psen_n_r;
    logic       rd_n_r;
    logic       wr_n_r;
    logic [7:0] p0_out_r;
    logic       p0_oe_r;
    logic [7:0] p2_out_r;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             ready_s;
    logic             strb_done_s;

`ifdef MCS51_XBUS_WAIT_EN
    assign ready_s = READY;
`else
    assign ready_s = 1'b1;
`endif

    assign strb_done_s = cnt_zero_s & ready_s;
    assign cnt_dec_s   = (state_r != ST_IDLE);

    // Phase counter reload at each phase entry.
    always_comb begin
        cnt_load_s = 1'b0;
        cnt_val_s  = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (REQ) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = ALE_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_ADDR: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = HOLD_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_zero_s) begin
                    cnt_load_s = 1'b1;
                    cnt_val_s  = STRB_LD;
                end else begin
                    cnt_load_s = 1'b0;
                end
            end
            default: cnt_load_s = 1'b0;
        endcase
    end

    xbus_phase_cnt u_phase_cnt (
        .clk      (CLK),
        .nrst     (nRST),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .zero     (cnt_zero_s)
    );

    // Sequencer FSM; every pad-facing output is set on the edge that enters its phase.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r  <= ST_IDLE;
            kind_r   <= XB_FETCH;
            wdata_r  <= 8'h00;
            busy_r   <= 1'b0;
            ack_r    <= 1'b0;
            rdata_r  <= 8'h00;
            ale_r    <= 1'b0;
            psen_n_r <= 1'b1;
            rd_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            p0_out_r <= 8'hFF;
            p0_oe_r  <= 1'b0;
            p2_out_r <= 8'h00;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (REQ) begin
                        state_r  <= ST_ADDR;
                        kind_r   <= kind_decode(KIND);
                        wdata_r  <= WDATA;
                        busy_r   <= 1'b1;
                        ale_r    <= 1'b1;
                        p0_oe_r  <= 1'b1;
                        p0_out_r <= ADDR[7:0];
                        p2_out_r <= ADDR[15:8];
                    end
                end
                ST_ADDR: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_HOLD;
                        ale_r   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero_s) begin
                        state_r <= ST_STRB;
                        case (kind_r)
                            XB_FETCH: begin
                                psen_n_r <= 1'b0;
                                p0_oe_r  <= 1'b0;
                            end
                            XB_WRITE: begin
                                wr_n_r   <= 1'b0;
                                p0_out_r <= wdata_r;
                            end
                            default: begin
                                rd_n_r  <= 1'b0;
                                p0_oe_r <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_STRB: begin
                    if (strb_done_s) begin
                        state_r  <= ST_RECOV;
                        psen_n_r <= 1'b1;
                        rd_n_r   <= 1'b1;
                        wr_n_r   <= 1'b1;
                        ack_r    <= 1'b1;
                        if (kind_r != XB_WRITE) begin
                            rdata_r <= P0_IN;
                        end
                    end
                end
                ST_RECOV: begin
                    // Write data was held through recovery; release the bus now.
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    p0_oe_r  <= 1'b0;
                    p0_out_r <= 8'hFF;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                    ale_r    <= 1'b0;
                    psen_n_r <= 1'b1;
                    rd_n_r   <= 1'b1;
                    wr_n_r   <= 1'b1;
                    p0_oe_r  <= 1'b0;
                    p0_out_r <= 8'hFF;
                end
            endcase
        end
    end

    assign BUSY   = busy_r;
    assign ACK    = ack_r;
    assign RDATA  = rdata_r;
    assign ALE    = ale_r;
    assign PSEN_n = psen_n_r;
    assign RD_n   = rd_n_r;
    assign WR_n   = wr_n_r;
    assign P0_OUT = p0_out_r;
    assign P0_OE  = p0_oe_r;
    assign P2_OUT = p2_out_r;

endmodule
